// File: rtl/seg_pkg.sv
// Shared definitions for the hex scan controller.
//
// Contents:
//   SEG_BLANK     - all-segments-off pattern (active-low)
//   digit_entry_t - per-digit display entry {blank, nibble}
//   scan_state_e  - scan phase within a digit slot
//   SEG_TABLE     - hex digit to {g,f,e,d,c,b,a} active-low patterns
//   ENTRY_RESET   - entry value held by every digit after reset (dark)
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef struct packed {
    logic       blank;
    logic [3:0] nibble;
  } digit_entry_t;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_e;

  // Index is the nibble value; patterns are active-low {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  localparam digit_entry_t ENTRY_RESET = '{blank: 1'b1, nibble: 4'h0};

endpackage

// File: rtl/hex_seg_decode.sv
// Combinational hex-to-seven-segment decoder.
//
// Ports:
//   nibble - hex value 0..F
//   seg    - active-low segment pattern {g,f,e,d,c,b,a}
module hex_seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_TABLE[nibble];
  end

endmodule

// File: rtl/hex_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode hex seven-segment digits.
// Holds a staging bank and an active bank of {blank, nibble} entries; the
// active bank is replaced atomically at the last cycle of a frame so a frame
// never shows a mix of old and new contents.
//
// Parameters:
//   NUM_DIGITS   - digits scanned (>= 2)
//   PRESCALE     - clock cycles per digit slot (>= 2)
//   BLANK_CYCLES - leading dark cycles in each slot (0 <= BLANK_CYCLES < PRESCALE)
//
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   wr_valid/wr_ready     - staging write handshake
//   wr_idx/wr_data/wr_blank - staging write payload (idx 0 = rightmost digit)
//   commit_valid/commit_ready - request to swap staging into active
//   commit_done           - one-cycle pulse when the swap takes effect
//   frame_start           - one-cycle pulse when digit 0's slot begins
//   seg                   - active-low segments {g,f,e,d,c,b,a}
//   an                    - active-low anode enables, at most one low
module hex_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [$clog2(NUM_DIGITS)-1:0] wr_idx,
  input  logic [3:0]                    wr_data,
  input  logic                          wr_blank,
  input  logic                          commit_valid,
  output logic                          commit_ready,
  output logic                          commit_done,
  output logic                          frame_start,
  output logic [6:0]                    seg,
  output logic [NUM_DIGITS-1:0]         an
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int PC_W  = $clog2(PRESCALE);

  localparam logic [PC_W-1:0]  PC_LAST = PC_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] DI_LAST = IDX_W'(NUM_DIGITS - 1);

  // Phase of a slot whose counter is zero; with no blanking the slot starts
  // straight in DRIVE.
  localparam scan_state_e STATE_AT_ZERO = (BLANK_CYCLES > 0) ? BLANK : DRIVE;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PC_W-1:0]  pc_reg, pc_next;
  logic [IDX_W-1:0] di_reg, di_next;
  scan_state_e      state_reg, state_next;
  logic             pending_reg, pending_next;

  digit_entry_t     staging_reg [NUM_DIGITS];
  digit_entry_t     active_reg  [NUM_DIGITS];

  logic [6:0]            seg_reg, seg_next;
  logic [NUM_DIGITS-1:0] an_reg, an_next;
  logic                  frame_wrap_reg;
  logic                  frame_start_reg;
  logic                  commit_done_reg;

  // ---------------------------------------------------------------------------
  // Handshakes: ready depends only on the registered pending flag.
  // ---------------------------------------------------------------------------
  logic wr_fire;
  logic commit_fire;
  logic frame_end;
  logic swap;

  assign wr_ready     = !pending_reg;
  assign commit_ready = !pending_reg;
  assign wr_fire      = wr_valid && !pending_reg;
  assign commit_fire  = commit_valid && !pending_reg;
  assign swap         = pending_reg && frame_end;

  // One-hot write decode. An index with no matching digit hits nothing, so
  // such a write is accepted and silently dropped.
  logic [NUM_DIGITS-1:0] wr_hit;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_wr_hit
    assign wr_hit[gi] = wr_fire && (wr_idx == IDX_W'(gi));
  end

  // ---------------------------------------------------------------------------
  // Staging and active banks
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        staging_reg[i] <= ENTRY_RESET;
        active_reg[i]  <= ENTRY_RESET;
      end
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (wr_hit[i]) begin
          staging_reg[i] <= '{blank: wr_blank, nibble: wr_data};
        end
        if (swap) begin
          active_reg[i] <= staging_reg[i];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Commit tracking. A commit and a swap can never coincide because a commit
  // is only accepted while nothing is pending.
  // ---------------------------------------------------------------------------
  always_comb begin
    pending_next = pending_reg;
    if (swap) begin
      pending_next = 1'b0;
    end else if (commit_fire) begin
      pending_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_reg <= 1'b0;
    end else begin
      pending_reg <= pending_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Shared decoder, fed by the active entry of the digit being scanned.
  // ---------------------------------------------------------------------------
  digit_entry_t cur_entry;
  logic [6:0]   dec_seg;

  assign cur_entry = active_reg[di_reg];

  hex_seg_decode u_decode (
    .nibble (cur_entry.nibble),
    .seg    (dec_seg)
  );

  // ---------------------------------------------------------------------------
  // Scan state machine: next state and next output values.
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_next    = pc_reg + 1'b1;
    di_next    = di_reg;
    frame_end  = 1'b0;
    an_next    = '1;
    seg_next   = SEG_BLANK;

    if (pc_reg == PC_LAST) begin
      pc_next   = '0;
      di_next   = (di_reg == DI_LAST) ? '0 : di_reg + 1'b1;
      frame_end = (di_reg == DI_LAST);
    end

    state_next = (int'(pc_next) < BLANK_CYCLES) ? BLANK : DRIVE;

    if (state_reg == DRIVE && !cur_entry.blank) begin
      an_next[di_reg] = 1'b0;
      seg_next        = dec_seg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg    <= '0;
      di_reg    <= '0;
      state_reg <= STATE_AT_ZERO;
    end else begin
      pc_reg    <= pc_next;
      di_reg    <= di_next;
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs. frame_start is delayed twice from frame_end so that it
  // lines up with the registered view of pc=0/di=0, and it cannot fire for the
  // partial "frame" that begins at reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_reg         <= SEG_BLANK;
      an_reg          <= '1;
      frame_wrap_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
      commit_done_reg <= 1'b0;
    end else begin
      seg_reg         <= seg_next;
      an_reg          <= an_next;
      frame_wrap_reg  <= frame_end;
      frame_start_reg <= frame_wrap_reg;
      commit_done_reg <= swap;
    end
  end

  assign seg         = seg_reg;
  assign an          = an_reg;
  assign frame_start = frame_start_reg;
  assign commit_done = commit_done_reg;

endmodule

// File: doc/hex_scan_ctrl.md
# hex_scan_ctrl

Time-multiplexed scan controller for a bank of common-anode hex seven-segment digits. It holds a double-buffered nibble per digit and shares one hex-to-segment decoder across all digits. It cycles the anode enables with a programmable dwell and a blanking interval, and applies new display contents atomically at frame boundaries. It sits between the register/status logic that produces display values and the board's segment/anode pins.

## Interface
- `NUM_DIGITS`, default 4: number of digits scanned; must be ≥ 2.
- `PRESCALE`, default 50000: clock cycles per digit slot; must be ≥ 2.
- `BLANK_CYCLES`, default 500: leading cycles of each slot with all anodes off; must satisfy 0 ≤ `BLANK_CYCLES` < `PRESCALE`.
- `clk`, input, 1: the single clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `wr_valid`, input, 1: staging write request.
- `wr_ready`, output, 1: staging write can be accepted.
- `wr_idx`, input, `$clog2(NUM_DIGITS)`: digit written; digit 0 is rightmost.
- `wr_data`, input, 4: hex value.
- `wr_blank`, input, 1: when 1, the digit is dark regardless of `wr_data`.
- `commit_valid`, input, 1: request to copy staging into active.
- `commit_ready`, output, 1: commit can be accepted.
- `commit_done`, output, 1: one-cycle pulse in the cycle the swap occurs.
- `frame_start`, output, 1: one-cycle pulse when digit 0's slot begins.
- `seg`, output, 7: segments `{g,f,e,d,c,b,a}`, active-low.
- `an`, output, `NUM_DIGITS`: anode enables, active-low, at most one bit low.

## Operation
- **Staging bank.** Each digit has a 5-bit staging entry `{blank, nibble}`.
  - A write is accepted when `wr_valid && wr_ready`.
  - If `wr_idx ≥ NUM_DIGITS`, the write is accepted and discarded.
- **Active bank.** A second set of per-digit entries drives the display. It is written only by a commit swap.
- **Commit handshake.**
  - `commit_ready = !pending`. An accepted commit sets `pending`.
  - While `pending`, `wr_ready = 0`.
  - The swap occurs on the first cycle with `pending && frame_end`. In that cycle: active ← staging (whole bank), `pending` clears, and `commit_done` pulses.
  - `frame_end` is the last cycle of digit `NUM_DIGITS-1`'s slot.
- **Write and commit in the same cycle.** The write is accepted (`pending` is not yet set) and is included in the commit.
- **Commit accepted on a `frame_end` cycle.** `pending` is registered, so that frame_end cannot satisfy it. The swap happens at the next `frame_end`.
- **Scan state machine.** States BLANK and DRIVE, with a prescale counter `pc` running 0..`PRESCALE-1` and a digit index `di`.
  - BLANK while `pc < BLANK_CYCLES`; DRIVE otherwise. If `BLANK_CYCLES` = 0, BLANK never occurs.
  - When `pc = PRESCALE-1`: `pc` ← 0 and `di` ← `di+1`. `di` wraps from `NUM_DIGITS-1` to 0.
- **Outputs.**
  - In BLANK, or in DRIVE when the active entry for `di` is blank: `an` is all ones and `seg` = `7'h7F`.
  - In DRIVE with a non-blank entry: `an[di]` = 0 and `seg` = decode(active nibble).
- **Decode table:**
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex)

## Timing
- **Reset values:**
  - `pc` = 0, `di` = 0, `pending` = 0.
  - Every staging and active entry = `{1, 4'h0}` (blank).
  - `an` all ones, `seg` = `7'h7F`.
  - `wr_ready` = 1, `commit_ready` = 1, `commit_done` = 0, `frame_start` = 0.
- **Registered outputs.** `seg`, `an`, `frame_start` and `commit_done` are registered. They reflect the `pc`/`di`/active-bank state of the previous cycle, which is one cycle of latency.
- **`frame_start` cycle.** `frame_start` is high in the cycle where `pc = 0` and `di = 0` are visible on the outputs. It does not pulse in the first cycle after reset. The first pulse follows the first wrap.
- **Swap visibility.** New active data first drives digit 0's DRIVE phase in the frame following `commit_done`. No frame ever mixes old and new banks.
- **Reset mid-operation.** Reset asserted at any point forces all reset values immediately (asynchronous). A pending commit is dropped and staging is cleared.
- **Handshake rule.** `wr_ready` and `commit_ready` depend only on registered state, never combinationally on `wr_valid` or `commit_valid`.

## Structure
- **Package `seg_pkg`:**
  - `SEG_BLANK` = `7'h7F`.
  - Typedef `digit_entry_t` (packed `{blank, nibble[3:0]}`).
  - Enum `scan_state_e` {BLANK, DRIVE}.
  - The 16-entry segment constant table.
- **Sub-module `hex_seg_decode`.** Combinational, nibble → 7-bit active-low pattern, using the package table. It is instantiated exactly once and fed by the active-bank mux.

## Test plan
All scenarios use `NUM_DIGITS`=4, `PRESCALE`=8, `BLANK_CYCLES`=2.

1. **Reset.** Hold `rst_n`=0 for 3 cycles, then release. Required: `an`=4'b1111 and `seg`=7'h7F for the whole of the first frame (all entries blank); `wr_ready`=1; `commit_ready`=1.
2. **Basic scan.** Write 1,2,3,4 to idx 0..3, then commit. Required: `commit_done` pulses at the frame_end. In the next frame, each slot shows 2 dark cycles, then 6 cycles of:
   - `an`=1110 with `seg`=79,
   - `an`=1101 with `seg`=24,
   - `an`=1011 with `seg`=30,
   - `an`=0111 with `seg`=19.
3. **Tearing guard.** Commit with idx 3 = F while the display is mid-frame. Required: `wr_valid` is ignored (`wr_ready`=0) until `commit_done`. Digit 3 still shows the old value for the rest of the current frame and shows 0E only from the next frame onward.
4. **Write and commit together.** Assert a write of idx 0 = A and `commit_valid` in the same cycle. Required: both are accepted, and after the swap digit 0 shows 08.
5. **Commit on frame_end.** Assert `commit_valid` exactly on a `frame_end` cycle. Required: no swap at that boundary; `commit_done` occurs 32 cycles later.
6. **Blank and out-of-range.** Write idx 2 with `wr_blank`=1, plus a write with `wr_idx`≥4 (parameterised width), then commit. Required: `an[2]` never goes low, and no other digit changes.
